arbiter_game_timers: RTL

ARBITER_GAME_TIMERS -- requirements
Module: arbiter_game_timers

---
 rtl/arbiter_game_timers.sv | 125 ++++++++++++
 1 files changed

// File: rtl/arbiter_game_timers.sv
// Game timers for the two-player arbiter: tick prescaler, countdown and winner timers, board LED driver.
// Latency: cd_done/w_done follow the counters combinationally; leds are registered (1 cycle from inputs/counters).
// Backpressure: none; this is a free-running timer block with level inputs and level outputs.
//
// Ports:
//   clk       system clock; every state update happens on its rising edge
//   rst_in    synchronous active-high reset
//   cd_rst    hold the countdown in reload while high
//   w_rst     hold the winner timer in reload while high; also clears the blink phase
//   leds_rst  force leds to 0000 while high
//   leds_sel  0 = countdown thermometer, 1 = winner blink pattern
//   gnt1/gnt2 grant/winner flags used to pick the blink pattern; gnt1 wins ties
//   cd_done   countdown expired (level)
//   w_done    winner display expired (level)
//   leds      active-high LED drive
//
// Build option: define ARBITER_GAME_FAST_TICK_EN to force a divider of 4 for fast simulation.
module arbiter_game_timers #(
    parameter int TICK_DIV = 12000000,
    parameter int CD_TICKS = 3,
    parameter int W_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       cd_rst,
    input  logic       w_rst,
    input  logic       leds_rst,
    input  logic       leds_sel,
    input  logic       gnt1,
    input  logic       gnt2,
    output logic       cd_done,
    output logic       w_done,
    output logic [3:0] leds
);

`ifdef ARBITER_GAME_FAST_TICK_EN
    localparam int DIV = 4;
`else
    localparam int DIV = TICK_DIV;
`endif

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [2:0]    CD_LOAD  = 3'(CD_TICKS);
    localparam logic [2:0]    W_LOAD   = 3'(W_TICKS);

    logic [PW-1:0] pre_cnt;
    logic [2:0]    cd_cnt;
    logic [2:0]    w_cnt;
    logic          phase;
    logic          tick;
    logic [3:0]    cd_bar;
    logic [3:0]    led_nxt;

    assign tick = (pre_cnt == PRE_LAST);

    // The reload inputs gate the done flags directly so a fresh reload reads
    // as "not done" in the same cycle it is asserted.
    assign cd_done = !rst_in && !cd_rst && (cd_cnt == 3'd0);
    assign w_done  = !rst_in && !w_rst  && (w_cnt  == 3'd0);

    // Thermometer of the countdown: bit i lit while more than i ticks remain.
    always_comb begin
        cd_bar = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cd_bar[i] = (i < int'(cd_cnt));
        end
    end

    always_comb begin
        led_nxt = 4'b0000;
        if (leds_rst) begin
            led_nxt = 4'b0000;
        end else if (!leds_sel) begin
            led_nxt = cd_bar;
        end else if (gnt1) begin
            led_nxt = {2'b00, phase, phase};
        end else if (gnt2) begin
            led_nxt = {phase, phase, 2'b00};
        end else begin
            led_nxt = {4{phase}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            pre_cnt <= '0;
            cd_cnt  <= CD_LOAD;
            w_cnt   <= W_LOAD;
            phase   <= 1'b0;
            leds    <= 4'b0000;
        end else begin
            // Either reload restarts the tick grid so the first tick after
            // release lands a full divider period later.
            if (cd_rst || w_rst || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end

            // Reload wins over a coincident tick; decrement saturates at 0.
            if (cd_rst) begin
                cd_cnt <= CD_LOAD;
            end else if (tick && (cd_cnt != 3'd0)) begin
                cd_cnt <= cd_cnt - 3'd1;
            end

            if (w_rst) begin
                w_cnt <= W_LOAD;
            end else if (tick && (w_cnt != 3'd0)) begin
                w_cnt <= w_cnt - 3'd1;
            end

            // Blink phase freezes once the winner display has run out.
            if (w_rst) begin
                phase <= 1'b0;
            end else if (tick && (w_cnt != 3'd0)) begin
                phase <= ~phase;
            end

            leds <= led_nxt;
        end
    end

endmodule
